// File: rtl/sap_pkg.sv
// Shared types and default constants for the SAP-1 clock-enable front end.
package sap_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_HIGH,
    S_WAIT,
    S_HALTED
  } state_t;

  localparam int CLKLEN_DEFAULT     = 4;
  localparam int DEB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/sap_debounce.sv
// Step-button conditioning: 2-flop synchronizer, debounce counter and
// rising-edge detector producing a single-cycle step request.
module sap_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic sysclk,
  input  logic reset,
  input  logic btn,
  output logic step_req
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          step_req_q, step_req_d;

  // The counter tracks consecutive samples disagreeing with the accepted level;
  // any agreeing sample restarts the count.
  always_comb begin
    sync1_d    = btn;
    sync2_d    = sync1_q;
    level_d    = level_q;
    cnt_d      = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
    step_req_d = level_d & ~level_q;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      cnt_q      <= '0;
      step_req_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      step_req_q <= step_req_d;
    end
  end

  assign step_req = step_req_q;

endmodule

// File: rtl/sap_clken_gen.sv
// Virtual CPU clock generator for sap1: programmable half-period, free-run or
// debounced single-step, and a halt that always finishes the current cycle.
module sap_clken_gen
  import sap_pkg::*;
#(
  parameter int CLKLEN     = CLKLEN_DEFAULT,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic sysclk,
  input  logic reset,
  input  logic run_mode,
  input  logic step_btn,
  input  logic halt,
  output logic clken,
  output logic clken_oop,
  output logic clk_vis,
  output logic running
);

  localparam int CW = $clog2(CLKLEN);
  localparam logic [CW-1:0] TC_VAL = CW'(CLKLEN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          clken_q, clken_d;
  logic          clken_oop_q, clken_oop_d;
  logic          step_req;
  logic          tc;

  sap_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .sysclk  (sysclk),
    .reset   (reset),
    .btn     (step_btn),
    .step_req(step_req)
  );

  assign tc = (count_q == TC_VAL);

  // halt and run_mode only matter at the end of the low phase or while
  // waiting, so a started high phase always runs to its falling edge.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    clken_d     = 1'b0;
    clken_oop_d = 1'b0;
    case (state_q)
      S_LOW: begin
        if (tc) begin
          count_d = '0;
          if (halt) begin
            state_d = S_HALTED;
          end else if (run_mode) begin
            clken_d = 1'b1;
            state_d = S_HIGH;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (tc) begin
          clken_oop_d = 1'b1;
          state_d     = S_LOW;
          count_d     = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_WAIT: begin
        count_d = '0;
        if (halt) begin
          state_d = S_HALTED;
        end else if (run_mode || step_req) begin
          clken_d = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HALTED: begin
        count_d = '0;
      end
      default: begin
        state_d = S_LOW;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= S_LOW;
      count_q     <= '0;
      clken_q     <= 1'b0;
      clken_oop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      clken_q     <= clken_d;
      clken_oop_q <= clken_oop_d;
    end
  end

  assign clken     = clken_q;
  assign clken_oop = clken_oop_q;
  assign clk_vis   = (state_q == S_HIGH);
  assign running   = (state_q == S_LOW) || (state_q == S_HIGH);

endmodule

// File: tb/tb_sap_clken_gen.sv
// Scoreboard bench for sap_clken_gen: stimulus queues expected enable pulses
// (kind and cycle), a negedge monitor pops and compares them as they appear.
module tb_sap_clken_gen;

  localparam int CLKLEN     = 4;
  localparam int DEB_CYCLES = 16;

  logic sysclk = 1'b0;
  logic reset;
  logic run_mode;
  logic step_btn;
  logic halt;
  logic clken;
  logic clken_oop;
  logic clk_vis;
  logic running;

  typedef struct {
    bit oop;
    int cyc;
  } pulse_t;

  pulse_t exp_q[$];
  int     edge_cnt = 0;
  int     checks   = 0;
  int     failures = 0;
  int     base;

  sap_clken_gen #(
    .CLKLEN    (CLKLEN),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .run_mode (run_mode),
    .step_btn (step_btn),
    .halt     (halt),
    .clken    (clken),
    .clken_oop(clken_oop),
    .clk_vis  (clk_vis),
    .running  (running)
  );

  always #5 sysclk = ~sysclk;

  // Edge N is the Nth rising edge; during the cycle after it edge_cnt == N.
  always @(posedge sysclk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rm, input logic hl, input logic sb);
    run_mode = rm;
    halt     = hl;
    step_btn = sb;
  endtask

  task automatic expectPulse(input bit oop, input int cyc);
    pulse_t p;
    p.oop = oop;
    p.cyc = cyc;
    exp_q.push_back(p);
  endtask

  task automatic waitUntil(input int target);
    while (edge_cnt < target) @(negedge sysclk);
  endtask

  // Called at a negedge: one reset edge, then outputs must be back to idle.
  task automatic applyReset();
    reset = 1'b1;
    @(negedge sysclk);
    checkOutput("reset_clken", clken, 0);
    checkOutput("reset_clken_oop", clken_oop, 0);
    checkOutput("reset_clk_vis", clk_vis, 0);
    checkOutput("reset_running", running, 1);
    reset = 1'b0;
    base  = edge_cnt;
  endtask

  // Monitor: every pulse must match the next expected one in kind and cycle.
  always @(negedge sysclk) begin
    pulse_t p;
    if (clken || clken_oop) begin
      checkOutput("pulse_exclusive", int'(clken && clken_oop), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse at edge %0d: clken=%b clken_oop=%b, expected no pulse",
                 edge_cnt, clken, clken_oop);
      end else begin
        p = exp_q.pop_front();
        checkOutput("pulse_kind_oop", clken_oop, p.oop);
        checkOutput("pulse_cycle", edge_cnt, p.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int m, p, q;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge sysclk);

    // Free run from reset, then halt raised during the high phase
    applyReset();
    expectPulse(0, base + 4);
    expectPulse(1, base + 8);
    expectPulse(0, base + 12);
    expectPulse(1, base + 16);
    expectPulse(0, base + 20);
    waitUntil(base + 2);
    checkOutput("fr_clk_vis_low", clk_vis, 0);
    checkOutput("fr_running", running, 1);
    waitUntil(base + 6);
    checkOutput("fr_clk_vis_high", clk_vis, 1);
    waitUntil(base + 10);
    checkOutput("fr_clk_vis_low2", clk_vis, 0);
    waitUntil(base + 21);
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectPulse(1, base + 24);
    waitUntil(base + 27);
    checkOutput("halt_running_before", running, 1);
    waitUntil(base + 29);
    checkOutput("halt_running", running, 0);
    checkOutput("halt_clk_vis", clk_vis, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitUntil(base + 45);
    checkOutput("halt_sticky_running", running, 0);
    checkOutput("halt_drain", exp_q.size(), 0);

    // Reset restores free run; reset again mid high phase
    applyReset();
    expectPulse(0, base + 4);
    expectPulse(1, base + 8);
    expectPulse(0, base + 12);
    waitUntil(base + 14);
    checkOutput("rst_mid_clk_vis", clk_vis, 1);
    applyReset();
    checkOutput("rst_mid_drain", exp_q.size(), 0);

    // Timing restarts as after a clean reset; run_mode drops in high phase
    expectPulse(0, base + 4);
    expectPulse(1, base + 8);
    expectPulse(0, base + 12);
    expectPulse(1, base + 16);
    waitUntil(base + 13);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(base + 19);
    checkOutput("to_wait_running_low_phase", running, 1);
    waitUntil(base + 21);
    checkOutput("wait_running", running, 0);
    checkOutput("wait_clk_vis", clk_vis, 0);
    waitUntil(base + 30);
    checkOutput("to_wait_drain", exp_q.size(), 0);

    // Two clean manual presses
    for (int k = 0; k < 2; k++) begin
      p = edge_cnt;
      applyStimulus(1'b0, 1'b0, 1'b1);
      expectPulse(0, p + 2 + DEB_CYCLES + 1);
      expectPulse(1, p + 2 + DEB_CYCLES + 1 + CLKLEN);
      waitUntil(p + 21);
      checkOutput("step_clk_vis", clk_vis, 1);
      waitUntil(p + 28);
      checkOutput("step_back_to_wait", running, 0);
      waitUntil(p + 40);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitUntil(p + 70);
      checkOutput("step_drain", exp_q.size(), 0);
    end

    // Bouncing button: toggles every 3 cycles, then settles high
    q = edge_cnt;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, ((i / 3) % 2) == 0);
      @(negedge sysclk);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectPulse(0, q + 30 + 19);
    expectPulse(1, q + 30 + 23);
    waitUntil(q + 80);
    checkOutput("bounce_drain", exp_q.size(), 0);
    checkOutput("bounce_wait", running, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(q + 110);

    // run_mode 0->1 in wait, press lands in a high phase, run_mode back to 0
    m = edge_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPulse(0, m + 1);
    expectPulse(1, m + 5);
    expectPulse(0, m + 9);
    expectPulse(1, m + 13);
    expectPulse(0, m + 17);
    expectPulse(1, m + 21);
    waitUntil(m + 2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitUntil(m + 18);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitUntil(m + 26);
    checkOutput("mode_back_to_wait", running, 0);
    waitUntil(m + 50);
    checkOutput("mode_drain", exp_q.size(), 0);
    checkOutput("mode_clk_vis", clk_vis, 0);

    // halt in wait wins over a later run_mode
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitUntil(m + 52);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitUntil(m + 62);
    checkOutput("halt_wait_running", running, 0);
    checkOutput("halt_wait_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_clken_gen.md
# sap_clken_gen

Clock-enable generator that sits directly upstream of `sap1` and drives its `clken` / `clken_oop` inputs from the single system clock. It divides `sysclk` into a virtual CPU clock with a programmable half-period. It supports free-run and front-panel single-step modes with a debounced step button. It stops issuing enables once `sap1` raises `halt`, always completing any half-finished CPU cycle before stopping.

## Interface
Parameters:
- `CLKLEN`, 4: `sysclk` cycles per half-period of the virtual clock; must be ≥ 2.
- `DEB_CYCLES`, 16: consecutive stable `sysclk` samples required to accept a new step-button level.

Ports:
- `sysclk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run_mode`  in  1  1 = free run, 0 = manual single-step.
- `step_btn`  in  1  raw front-panel step button; asynchronous and bouncing.
- `halt`  in  1  halt flag from `sap1`.
- `clken`  out  1  one-`sysclk` pulse at each virtual rising edge.
- `clken_oop`  out  1  one-`sysclk` pulse at each virtual falling edge.
- `clk_vis`  out  1  virtual clock level, for LED/debug use.
- `running`  out  1  high in S_LOW and S_HIGH; low in S_WAIT and S_HALTED.

## Operation
- Phase counter `count` runs 0..CLKLEN-1 and wraps to 0. The terminal count (TC) is `count == CLKLEN-1`.
- States and transitions:
  - **S_LOW** (`clk_vis`=0), evaluated at TC:
    - `halt` → S_HALTED.
    - else `run_mode` → pulse `clken`, go to S_HIGH, `count`=0.
    - else → S_WAIT.
  - **S_HIGH** (`clk_vis`=1): at TC → pulse `clken_oop`, go to S_LOW, `count`=0. `halt` and `run_mode` are ignored in S_HIGH, so the cycle always completes.
  - **S_WAIT** (`clk_vis`=0, `count` held at 0), priority order:
    - `halt` → S_HALTED.
    - else `run_mode`=1 → pulse `clken`, go to S_HIGH.
    - else a step request → pulse `clken`, go to S_HIGH.
  - **S_HALTED**: no pulses, `clk_vis`=0. Only `reset` exits this state; deasserting `halt` does not.
- `clken` and `clken_oop` are registered and are never high in the same cycle.
- Step path:
  - 2-flop synchronizer feeds a debounce counter.
  - The debounced level changes only after DEB_CYCLES consecutive samples that differ from it.
  - A debounced 0→1 transition produces a one-cycle step request.
  - Requests arriving outside S_WAIT are dropped, not queued.
- Reset (any state, mid-cycle included):
  - Next edge: state S_LOW, `count`=0, `clk_vis`=0, `clken`=0, `clken_oop`=0.
  - Synchronizer and debounce level/counter cleared; pending request dropped.
  - `running`=1.

## Timing
- Free run: edges are counted from the first edge with `reset` low as edge 1.
  - `clken` is high in the cycle after edge CLKLEN, then every 2·CLKLEN edges.
  - `clken_oop` is high in the cycle after edge 2·CLKLEN, then every 2·CLKLEN edges.
  - `clk_vis` changes in the same edge as the corresponding pulse.
- Manual mode, from a clean press while in S_WAIT:
  - `clken` follows after 2 (sync) + DEB_CYCLES + 1 edges.
  - `clken_oop` follows CLKLEN edges later.
  - The block then spends CLKLEN edges in S_LOW before entering S_WAIT.
- `halt` latency: sampled only at S_LOW TC and in S_WAIT. At most one further `clken_oop` is issued after `halt` rises.
- `run_mode` 1→0 takes effect at the next S_LOW TC. `run_mode` 0→1 in S_WAIT gives a `clken` on the next edge.

## Structure
- Shared package `sap_pkg` holds:
  - the state enum (S_LOW, S_HIGH, S_WAIT, S_HALTED);
  - the default constants CLKLEN=4 and DEB_CYCLES=16.
- Counter widths:
  - `count`: $clog2(CLKLEN).
  - debounce counter: $clog2(DEB_CYCLES+1).
- One sub-module, `sap_debounce`: synchronizer, debounce counter and rising-edge detector. Its output is a single-cycle `step_req`.

## Test plan
- **Free run**, CLKLEN=4, `run_mode`=1, `reset` for 1 cycle → `clken` after edges 4, 12, 20; `clken_oop` after edges 8, 16; never both high; `running`=1 throughout.
- **Halt** raised during S_HIGH → one `clken_oop` still issued, then S_HALTED, `running`=0 and no further pulses. Dropping `halt` has no effect; `reset` restores free run.
- **Manual step**, `run_mode`=0, clean 40-cycle press → exactly one `clken`, then `clken_oop` 4 edges later, then return to S_WAIT. A second press yields a second cycle.
- **Bouncing button**: `step_btn` toggles every 3 cycles for 30 cycles, then stays high → exactly one step. A press during S_HIGH → no extra step.
- **Mode switch**:
  - `run_mode` 0→1 in S_WAIT → `clken` next edge, then free-run cadence.
  - `run_mode` 1→0 during S_HIGH → the cycle completes, then S_WAIT.
- **Reset during S_HIGH** with `clken_oop` pending → all outputs 0 on the next edge, and timing restarts exactly as in the free-run scenario.
